// File: rtl/usb3_ep0_pkg.sv
// Shared definitions for the EP0 control-transfer sequencer: state encodings,
// standard request codes and the decoded SETUP packet layout.
package usb3_ep0_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_REQ_WAIT = 3'd3,
    ST_DATA_IN  = 3'd4,
    ST_DATA_OUT = 3'd5,
    ST_STATUS   = 3'd6,
    ST_STALL    = 3'd7
  } ep0_state_t;

  localparam logic [7:0] REQ_GET_STATUS        = 8'd0;
  localparam logic [7:0] REQ_CLEAR_FEATURE     = 8'd1;
  localparam logic [7:0] REQ_SET_FEATURE       = 8'd3;
  localparam logic [7:0] REQ_SET_ADDRESS       = 8'd5;
  localparam logic [7:0] REQ_GET_DESCRIPTOR    = 8'd6;
  localparam logic [7:0] REQ_SET_DESCRIPTOR    = 8'd7;
  localparam logic [7:0] REQ_GET_CONFIGURATION = 8'd8;
  localparam logic [7:0] REQ_SET_CONFIGURATION = 8'd9;
  localparam logic [7:0] REQ_GET_INTERFACE     = 8'd10;
  localparam logic [7:0] REQ_SET_INTERFACE     = 8'd11;
  localparam logic [7:0] REQ_SYNCH_FRAME       = 8'd12;
  localparam logic [7:0] REQ_SET_SEL           = 8'd48;

  localparam logic       HOST_TO_DEVICE      = 1'b0;
  localparam logic       DEVICE_TO_HOST      = 1'b1;
  localparam logic [1:0] SETUP_TYPE_STANDARD = 2'b00;

  typedef struct packed {
    logic [7:0]  bm_request_type;
    logic [7:0]  b_request;
    logic [15:0] w_value;
    logic [15:0] w_index;
    logic [15:0] w_length;
  } setup_pkt_t;

  function automatic logic is_set_address(input setup_pkt_t p);
    return (p.bm_request_type[7]   == HOST_TO_DEVICE) &&
           (p.bm_request_type[6:5] == SETUP_TYPE_STANDARD) &&
           (p.bm_request_type[4:0] == 5'd0) &&
           (p.b_request            == REQ_SET_ADDRESS);
  endfunction

endpackage

// File: rtl/usb3_ep0_ctrl_seq_if.sv
// EP0 buffer / user-request signal bundle between the protocol layer, the
// user request logic (master side) and the control sequencer (slave side).
interface usb3_ep0_ctrl_seq_if;
    logic        setup_wren;
    logic [31:0] setup_data;
    logic        setup_commit;
    logic [10:0] setup_commit_len;
    logic        in_commit;
    logic [10:0] in_commit_len;
    logic        in_pkt_acked;
    logic        out_commit;
    logic [10:0] out_commit_len;
    logic        req_ack;
    logic        req_stall;
    logic        status_done;
    logic        set_address_ack;

    logic        request_valid;
    logic [7:0]  bmRequestType;
    logic [7:0]  bRequest;
    logic [15:0] wValue;
    logic [15:0] wIndex;
    logic [15:0] wLength;
    logic [2:0]  ctrl_state;
    logic [15:0] bytes_left;
    logic        enter_status;
    logic        ep0_stall;
    logic        set_address;
    logic [6:0]  dev_address;
    logic        err_setup_pkt;
    logic        setup_abort;
    logic        status_timeout;

    modport master (
        output setup_wren, setup_data, setup_commit, setup_commit_len,
               in_commit, in_commit_len, in_pkt_acked, out_commit, out_commit_len,
               req_ack, req_stall, status_done, set_address_ack,
        input  request_valid, bmRequestType, bRequest, wValue, wIndex, wLength,
               ctrl_state, bytes_left, enter_status, ep0_stall, set_address,
               dev_address, err_setup_pkt, setup_abort, status_timeout
    );

    modport slave (
        input  setup_wren, setup_data, setup_commit, setup_commit_len,
               in_commit, in_commit_len, in_pkt_acked, out_commit, out_commit_len,
               req_ack, req_stall, status_done, set_address_ack,
        output request_valid, bmRequestType, bRequest, wValue, wIndex, wLength,
               ctrl_state, bytes_left, enter_status, ep0_stall, set_address,
               dev_address, err_setup_pkt, setup_abort, status_timeout
    );
endinterface

// File: rtl/usb3_ep0_setup_cap.sv
// Two-word SETUP packet capture: counts written words, validates the commit
// and latches the decoded request fields when the packet is well formed.
module usb3_ep0_setup_cap
    import usb3_ep0_pkg::*;
(
    input  logic        local_clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        wren,
    input  logic        commit,
    input  logic [31:0] data,
    input  logic [10:0] commit_len,
    output logic        commit_ok,
    output logic        commit_bad,
    output setup_pkt_t  pkt
);

    logic [1:0]  word_cnt;
    logic [31:0] word0;
    logic [31:0] word1;

    assign commit_ok  = commit && (commit_len == 11'd8) && (word_cnt == 2'd2);
    assign commit_bad = commit && !commit_ok;

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // the two word buffers are plain flops and are reset like the rest.
    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt <= 2'd0;
            word0    <= '0;
            word1    <= '0;
            pkt      <= '0;
        end else begin
            if (start) begin
                word0    <= data;
                word_cnt <= 2'd1;
            end else if (wren) begin
                if (word_cnt == 2'd0) word0 <= data;
                else if (word_cnt == 2'd1) word1 <= data;
                if (word_cnt != 2'd3) word_cnt <= word_cnt + 2'd1;
            end else if (commit) begin
                word_cnt <= 2'd0;
            end

            if (commit_ok) begin
                pkt.bm_request_type <= word0[31:24];
                pkt.b_request       <= word0[23:16];
                pkt.w_value         <= {word0[7:0], word0[15:8]};
                pkt.w_index         <= {word1[23:16], word1[31:24]};
                pkt.w_length        <= {word1[7:0], word1[15:8]};
            end
        end
    end

endmodule

// File: rtl/usb3_ep0_ctrl_seq.sv
// EP0 control-transfer sequencer: SETUP -> DATA IN/OUT -> STATUS with wLength
// accounting, user request handshake, stall handling and status timeout.
module usb3_ep0_ctrl_seq
    import usb3_ep0_pkg::*;
#(
    parameter int MAX_PKT   = 512,
    parameter int STATUS_TO = 65535,
    parameter int TO_W      = 16
) (
    input logic               local_clk,
    input logic               reset_n,
    usb3_ep0_ctrl_seq_if.slave bus
);

    localparam logic [15:0]     MAX_PKT_W = 16'(MAX_PKT);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(STATUS_TO - 1);
    localparam bit              TO_EN     = (STATUS_TO != 0);

    ep0_state_t      state, state_next;
    setup_pkt_t      pkt;
    logic            cap_start, cap_commit, commit_ok, commit_bad;
    logic            decode_addr, abort_evt, to_evt, last_pkt;
    logic [15:0]     bytes_left, in_len, out_len, in_take, in_rem, out_rem;
    logic [TO_W-1:0] to_cnt;
    logic            request_valid, enter_status, ep0_stall, set_address;
    logic            err_setup_pkt, setup_abort, status_timeout;
    logic [6:0]      dev_address;

    assign cap_start   = bus.setup_wren && (state != ST_SETUP);
    assign cap_commit  = bus.setup_commit && !bus.setup_wren && (state == ST_SETUP);
    assign decode_addr = (state == ST_DECODE) && !bus.setup_wren && is_set_address(pkt);

    assign in_len  = {5'd0, bus.in_commit_len};
    assign out_len = {5'd0, bus.out_commit_len};
    assign in_take = (in_len > bytes_left) ? bytes_left : in_len;  // over-long IN is truncated
    assign in_rem  = bytes_left - in_take;
    assign out_rem = bytes_left - out_len;

    usb3_ep0_setup_cap u_setup_cap (
        .local_clk  (local_clk),
        .reset_n    (reset_n),
        .start      (cap_start),
        .wren       (bus.setup_wren),
        .commit     (cap_commit),
        .data       (bus.setup_data),
        .commit_len (bus.setup_commit_len),
        .commit_ok  (commit_ok),
        .commit_bad (commit_bad),
        .pkt        (pkt)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        abort_evt  = 1'b0;
        to_evt     = 1'b0;
        if (bus.setup_wren) begin
            state_next = ST_SETUP;
            abort_evt  = (state != ST_IDLE) && (state != ST_SETUP);
        end else begin
            case (state)
                ST_SETUP: begin
                    if (commit_ok)       state_next = ST_DECODE;
                    else if (commit_bad) state_next = ST_IDLE;
                end
                ST_DECODE: state_next = is_set_address(pkt) ? ST_STATUS : ST_REQ_WAIT;
                ST_REQ_WAIT: begin
                    if (bus.req_stall) state_next = ST_STALL;
                    else if (bus.req_ack) begin
                        if (pkt.w_length == 16'd0)                          state_next = ST_STATUS;
                        else if (pkt.bm_request_type[7] == DEVICE_TO_HOST) state_next = ST_DATA_IN;
                        else                                                state_next = ST_DATA_OUT;
                    end
                end
                ST_DATA_IN: if (bus.in_pkt_acked && last_pkt) state_next = ST_STATUS;
                ST_DATA_OUT: begin
                    if (bus.out_commit) begin
                        if (out_len > bytes_left)                            state_next = ST_STALL;
                        else if (out_rem == 16'd0 || out_len < MAX_PKT_W)   state_next = ST_STATUS;
                    end
                end
                ST_STATUS: begin
                    if (bus.status_done) state_next = ST_IDLE;
                    else if (TO_EN && to_cnt == TO_LAST) begin
                        state_next = ST_IDLE;
                        to_evt     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            bytes_left     <= '0;
            last_pkt       <= 1'b0;
            to_cnt         <= '0;
            request_valid  <= 1'b0;
            enter_status   <= 1'b0;
            ep0_stall      <= 1'b0;
            set_address    <= 1'b0;
            dev_address    <= '0;
            err_setup_pkt  <= 1'b0;
            setup_abort    <= 1'b0;
            status_timeout <= 1'b0;
        end else begin
            state          <= state_next;
            request_valid  <= (state_next == ST_REQ_WAIT);
            enter_status   <= (state_next == ST_STATUS) && (state != ST_STATUS);
            ep0_stall      <= (state_next == ST_STALL);
            err_setup_pkt  <= commit_bad;
            setup_abort    <= abort_evt;
            status_timeout <= to_evt;
            to_cnt         <= (state == ST_STATUS) ? to_cnt + TO_W'(1) : '0;

            if (state == ST_DECODE && !bus.setup_wren) begin
                bytes_left <= pkt.w_length;
                last_pkt   <= 1'b0;
            end else if (state == ST_DATA_IN && bus.in_commit && !bus.setup_wren) begin
                bytes_left <= in_rem;
                last_pkt   <= (in_len < MAX_PKT_W) || (in_rem == 16'd0);
            end else if (state == ST_DATA_OUT && bus.out_commit && !bus.setup_wren &&
                         out_len <= bytes_left) begin
                bytes_left <= out_rem;
            end

            if (bus.set_address_ack) set_address <= 1'b0;
            else if (decode_addr)    set_address <= 1'b1;
            if (decode_addr) dev_address <= pkt.w_value[6:0];
        end
    end

    assign bus.ctrl_state     = state;
    assign bus.bytes_left     = bytes_left;
    assign bus.request_valid  = request_valid;
    assign bus.enter_status   = enter_status;
    assign bus.ep0_stall      = ep0_stall;
    assign bus.set_address    = set_address;
    assign bus.dev_address    = dev_address;
    assign bus.err_setup_pkt  = err_setup_pkt;
    assign bus.setup_abort    = setup_abort;
    assign bus.status_timeout = status_timeout;
    assign bus.bmRequestType  = pkt.bm_request_type;
    assign bus.bRequest       = pkt.b_request;
    assign bus.wValue         = pkt.w_value;
    assign bus.wIndex         = pkt.w_index;
    assign bus.wLength        = pkt.w_length;

endmodule

// File: tb/tb_usb3_ep0_ctrl_seq.sv
// Self-checking bench for usb3_ep0_ctrl_seq: directed control transfers plus
// randomized IN/OUT data stages scored against a wLength/packet-rule model.
module tb_usb3_ep0_ctrl_seq;

    localparam int S_IDLE = 0, S_SETUP = 1, S_DECODE = 2, S_REQ_WAIT = 3;
    localparam int S_DATA_IN = 4, S_DATA_OUT = 5, S_STATUS = 6, S_STALL = 7;
    localparam int MPS = 512;
    localparam int TO  = 16;

    typedef enum int {P_REQ_ACK, P_REQ_BOTH, P_IN_COMMIT, P_IN_ACK,
                      P_OUT_COMMIT, P_STATUS_DONE, P_ADDR_ACK} pulse_e;

    logic local_clk = 1'b0;
    logic reset_n;
    int   checks    = 0;
    int   errors    = 0;
    int   exp_state = S_IDLE;
    logic [7:0]  exp_bm = '0, exp_br = '0;
    logic [15:0] exp_wv = '0, exp_wi = '0, exp_wl = '0;

    usb3_ep0_ctrl_seq_if bus();

    usb3_ep0_ctrl_seq #(.MAX_PKT(MPS), .STATUS_TO(TO), .TO_W(16)) dut (
        .local_clk (local_clk),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #5 local_clk = ~local_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int exp);
        check(tag, 32'(bus.ctrl_state), exp);
    endtask

    task automatic chk_fields();
        check("bmRequestType", 32'(bus.bmRequestType), 32'(exp_bm));
        check("bRequest",      32'(bus.bRequest),      32'(exp_br));
        check("wValue",        32'(bus.wValue),        32'(exp_wv));
        check("wIndex",        32'(bus.wIndex),        32'(exp_wi));
        check("wLength",       32'(bus.wLength),       32'(exp_wl));
    endtask

    task automatic tick();
        @(posedge local_clk);
        #1;
    endtask

    task automatic wr_word(input logic [31:0] w);
        bus.setup_wren = 1'b1;
        bus.setup_data = w;
        tick();
        bus.setup_wren = 1'b0;
    endtask

    task automatic commit_setup(input logic [10:0] len);
        bus.setup_commit     = 1'b1;
        bus.setup_commit_len = len;
        tick();
        bus.setup_commit = 1'b0;
    endtask

    task automatic strobe(input pulse_e p, input logic [10:0] len = 11'd0);
        case (p)
            P_REQ_ACK:     bus.req_ack = 1'b1;
            P_REQ_BOTH:    begin bus.req_ack = 1'b1; bus.req_stall = 1'b1; end
            P_IN_COMMIT:   begin bus.in_commit = 1'b1; bus.in_commit_len = len; end
            P_IN_ACK:      bus.in_pkt_acked = 1'b1;
            P_OUT_COMMIT:  begin bus.out_commit = 1'b1; bus.out_commit_len = len; end
            P_STATUS_DONE: bus.status_done = 1'b1;
            P_ADDR_ACK:    bus.set_address_ack = 1'b1;
            default: ;
        endcase
        tick();
        bus.req_ack = 1'b0; bus.req_stall = 1'b0; bus.in_commit = 1'b0;
        bus.in_pkt_acked = 1'b0; bus.out_commit = 1'b0; bus.status_done = 1'b0;
        bus.set_address_ack = 1'b0;
    endtask

    // Full valid SETUP; an abort is expected whenever the transfer in flight
    // was past IDLE/SETUP.
    task automatic send_setup(input logic [7:0] bm, input logic [7:0] br,
                              input logic [15:0] wv, input logic [15:0] wi,
                              input logic [15:0] wl);
        logic abort_exp;
        abort_exp = !(exp_state == S_IDLE || exp_state == S_SETUP);
        wr_word({bm, br, wv[7:0], wv[15:8]});
        chk_state("setup_w0_state", S_SETUP);
        check("setup_abort", 32'(bus.setup_abort), 32'(abort_exp));
        check("stall_cleared", 32'(bus.ep0_stall), 0);
        wr_word({wi[7:0], wi[15:8], wl[7:0], wl[15:8]});
        check("setup_abort_w1", 32'(bus.setup_abort), 0);
        commit_setup(11'd8);
        exp_bm = bm; exp_br = br; exp_wv = wv; exp_wi = wi; exp_wl = wl;
        exp_state = S_DECODE;
        chk_state("decode_state", S_DECODE);
        chk_fields();
    endtask

    task automatic to_req_wait();
        tick();
        exp_state = S_REQ_WAIT;
        chk_state("req_wait_state", S_REQ_WAIT);
        check("request_valid", 32'(bus.request_valid), 1);
        check("bytes_left_init", 32'(bus.bytes_left), 32'(exp_wl));
    endtask

    task automatic finish_status();
        strobe(P_STATUS_DONE);
        exp_state = S_IDLE;
        chk_state("status_done_idle", S_IDLE);
    endtask

    task automatic run_in(input logic [15:0] wl);
        int rem, len, take, n;
        bit last;
        rem = int'(wl); n = 0; last = 1'b0;
        send_setup(8'h80, 8'h06, 16'h0100, 16'h0000, wl);
        to_req_wait();
        strobe(P_REQ_ACK);
        exp_state = S_DATA_IN;
        chk_state("rin_ack", S_DATA_IN);
        while (!last && n < 8) begin
            len = (n < 2 && $urandom_range(0, 2) != 0) ? MPS : $urandom_range(0, MPS - 1);
            if ($urandom_range(0, 4) == 0) len = rem + $urandom_range(1, 100);
            if (len > 2047) len = 2047;
            take = (len > rem) ? rem : len;
            rem  = rem - take;
            last = (len < MPS) || (rem == 0);
            strobe(P_IN_COMMIT, 11'(len));
            check("rin_bytes_left", 32'(bus.bytes_left), rem);
            strobe(P_IN_ACK);
            exp_state = last ? S_STATUS : S_DATA_IN;
            chk_state("rin_after_ack", exp_state);
            n++;
        end
        check("rin_enter_status", 32'(bus.enter_status), 1);
        finish_status();
    endtask

    task automatic run_out(input logic [15:0] wl);
        int rem, len, n, r;
        bit done;
        rem = int'(wl); n = 0; done = 1'b0;
        send_setup(8'h40, 8'h01, 16'h0000, 16'h0003, wl);
        to_req_wait();
        strobe(P_REQ_ACK);
        exp_state = S_DATA_OUT;
        chk_state("rout_ack", S_DATA_OUT);
        while (!done && n < 8) begin
            r = $urandom_range(0, 3);
            if (r == 0)                            len = rem + $urandom_range(1, 40);
            else if (r == 1 || n >= 3 || rem < MPS) len = $urandom_range(0, (rem < MPS - 1) ? rem : MPS - 1);
            else                                   len = MPS;
            strobe(P_OUT_COMMIT, 11'(len));
            if (len > rem) begin
                exp_state = S_STALL; done = 1'b1;
                check("rout_babble_stall", 32'(bus.ep0_stall), 1);
            end else begin
                rem = rem - len;
                if (rem == 0 || len < MPS) begin exp_state = S_STATUS; done = 1'b1; end
            end
            chk_state("rout_state", exp_state);
            check("rout_bytes_left", 32'(bus.bytes_left), rem);
            n++;
        end
        if (exp_state == S_STATUS) finish_status();
    endtask

    initial begin
        reset_n = 1'b0;
        bus.setup_wren = 1'b0; bus.setup_data = '0; bus.setup_commit = 1'b0;
        bus.setup_commit_len = '0; bus.in_commit = 1'b0; bus.in_commit_len = '0;
        bus.in_pkt_acked = 1'b0; bus.out_commit = 1'b0; bus.out_commit_len = '0;
        bus.req_ack = 1'b0; bus.req_stall = 1'b0; bus.status_done = 1'b0;
        bus.set_address_ack = 1'b0;
        repeat (3) tick();
        chk_state("reset_state", S_IDLE);
        check("reset_request_valid", 32'(bus.request_valid), 0);
        check("reset_stall", 32'(bus.ep0_stall), 0);
        check("reset_set_address", 32'(bus.set_address), 0);
        check("reset_dev_address", 32'(bus.dev_address), 0);
        check("reset_bytes_left", 32'(bus.bytes_left), 0);
        check("reset_pulses", 32'({bus.enter_status, bus.err_setup_pkt,
                                   bus.setup_abort, bus.status_timeout}), 0);
        chk_fields();
        reset_n = 1'b1;
        tick();

        // GET_DESCRIPTOR 80 06 00 01 00 00 12 00, single 18-byte IN packet
        send_setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0012);
        to_req_wait();
        tick();
        check("request_valid_held", 32'(bus.request_valid), 1);
        strobe(P_REQ_ACK);
        exp_state = S_DATA_IN;
        chk_state("gd_data_in", S_DATA_IN);
        check("gd_rv_dropped", 32'(bus.request_valid), 0);
        strobe(P_IN_COMMIT, 11'd18);
        check("gd_bytes_left", 32'(bus.bytes_left), 0);
        strobe(P_IN_ACK);
        exp_state = S_STATUS;
        chk_state("gd_status", S_STATUS);
        check("gd_enter_status", 32'(bus.enter_status), 1);
        tick();
        check("gd_enter_status_1cyc", 32'(bus.enter_status), 0);
        finish_status();

        // SET_ADDRESS 0x23: straight to STATUS, set_address held until acked
        send_setup(8'h00, 8'h05, 16'h0023, 16'h0000, 16'h0000);
        tick();
        exp_state = S_STATUS;
        chk_state("sa_status_next", S_STATUS);
        check("sa_no_request_valid", 32'(bus.request_valid), 0);
        check("sa_dev_address", 32'(bus.dev_address), 32'h23);
        check("sa_set_address", 32'(bus.set_address), 1);
        finish_status();
        repeat (3) tick();
        check("sa_held", 32'(bus.set_address), 1);
        strobe(P_ADDR_ACK);
        check("sa_cleared", 32'(bus.set_address), 0);
        check("sa_dev_kept", 32'(bus.dev_address), 32'h23);

        // SET_SEL OUT wLength 6 receiving 8 bytes: babble stall
        send_setup(8'h00, 8'h30, 16'h0000, 16'h0000, 16'h0006);
        to_req_wait();
        strobe(P_REQ_ACK);
        exp_state = S_DATA_OUT;
        strobe(P_OUT_COMMIT, 11'd8);
        exp_state = S_STALL;
        chk_state("ss_stall_state", S_STALL);
        check("ss_ep0_stall", 32'(bus.ep0_stall), 1);
        tick();
        check("ss_stall_held", 32'(bus.ep0_stall), 1);

        // IN wLength 1024: 512 then 100, then let STATUS time out
        send_setup(8'h80, 8'h06, 16'h0200, 16'h0000, 16'd1024);
        to_req_wait();
        strobe(P_REQ_ACK);
        exp_state = S_DATA_IN;
        strobe(P_IN_COMMIT, 11'd512);
        check("in1k_bl_512", 32'(bus.bytes_left), 512);
        strobe(P_IN_ACK);
        chk_state("in1k_not_last", S_DATA_IN);
        strobe(P_IN_COMMIT, 11'd100);
        check("in1k_bl_412", 32'(bus.bytes_left), 412);
        strobe(P_IN_ACK);
        exp_state = S_STATUS;
        chk_state("in1k_status", S_STATUS);
        for (int i = 2; i <= TO; i++) begin
            tick();
            chk_state("to_still_status", S_STATUS);
            check("to_no_early_pulse", 32'(bus.status_timeout), 0);
        end
        tick();
        exp_state = S_IDLE;
        chk_state("to_idle", S_IDLE);
        check("to_pulse", 32'(bus.status_timeout), 1);
        tick();
        check("to_pulse_1cyc", 32'(bus.status_timeout), 0);

        // New SETUP pre-empting DATA_OUT
        send_setup(8'h40, 8'h02, 16'h0000, 16'h0000, 16'd64);
        to_req_wait();
        strobe(P_REQ_ACK);
        exp_state = S_DATA_OUT;
        chk_state("ab_data_out", S_DATA_OUT);
        send_setup(8'h00, 8'h09, 16'h0001, 16'h0000, 16'h0000);
        to_req_wait();
        strobe(P_REQ_ACK);
        exp_state = S_STATUS;
        chk_state("ab_status_wl0", S_STATUS);
        finish_status();

        // Malformed SETUP packets: fields must not change
        wr_word(32'hDEADBEEF); wr_word(32'h12345678); commit_setup(11'd6);
        chk_state("err_len6_idle", S_IDLE);
        check("err_len6_pulse", 32'(bus.err_setup_pkt), 1);
        chk_fields();
        tick();
        check("err_pulse_1cyc", 32'(bus.err_setup_pkt), 0);
        wr_word(32'hCAFEF00D); commit_setup(11'd8);
        check("err_one_word", 32'(bus.err_setup_pkt), 1);
        wr_word(32'h1); wr_word(32'h2); wr_word(32'h3); commit_setup(11'd8);
        check("err_three_words", 32'(bus.err_setup_pkt), 1);
        chk_state("err_three_idle", S_IDLE);
        chk_fields();

        // req_stall wins over a simultaneous req_ack
        send_setup(8'h80, 8'h00, 16'h0000, 16'h0000, 16'h0002);
        to_req_wait();
        strobe(P_REQ_BOTH);
        exp_state = S_STALL;
        chk_state("both_stall", S_STALL);
        check("both_rv_low", 32'(bus.request_valid), 0);

        // set_address_ack coinciding with the DECODE set wins
        send_setup(8'h00, 8'h05, 16'h0041, 16'h0000, 16'h0000);
        strobe(P_ADDR_ACK);
        exp_state = S_STATUS;
        check("ack_wins_set", 32'(bus.set_address), 0);
        check("ack_wins_addr", 32'(bus.dev_address), 32'h41);
        finish_status();

        for (int k = 0; k < 4; k++) run_in(16'($urandom_range(1, 1500)));
        for (int k = 0; k < 6; k++) run_out(16'($urandom_range(1, 1500)));

        // status_done on the timeout cycle: no pulse
        send_setup(8'h00, 8'h09, 16'h0002, 16'h0000, 16'h0000);
        to_req_wait();
        strobe(P_REQ_ACK);
        exp_state = S_STATUS;
        for (int i = 2; i <= TO; i++) tick();
        chk_state("tod_last_cycle", S_STATUS);
        strobe(P_STATUS_DONE);
        exp_state = S_IDLE;
        chk_state("tod_idle", S_IDLE);
        check("tod_no_pulse", 32'(bus.status_timeout), 0);
        tick();
        check("tod_no_pulse_late", 32'(bus.status_timeout), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
